// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_OP_MAX = ALU_SRA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side request/response bundle; requesters drive the master view, the controller the slave view.
interface alu_share_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_result;
  logic [3:0]               resp_flags;
  logic                     resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW:0] w_cand;
  logic        w_found;

  // One extra bit on the candidate so ptr+i can wrap without overflowing.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = {1'b0, ptr} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(N)) w_cand = w_cand - (IW+1)'(N);
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found                = 1'b1;
        gnt[w_cand[IW-1:0]]    = 1'b1;
        gnt_idx                = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequences one external combinational ALU among NUM_REQ requesters: grant, hold operands
// for the op's cycle count, then present a registered result to the owner until accepted.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int WIDTH         = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MULDIV_CYCLES + 1);

  state_e             r_state, w_next;
  logic [IW-1:0]      r_ptr, r_owner, w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt, w_owner_oh, r_resp_valid;
  logic [CW-1:0]      r_cnt, w_cnt_load;
  logic [WIDTH-1:0]   r_alu_a, r_alu_b, r_resp_result, w_sel_a, w_sel_b;
  logic [3:0]         r_alu_ctrl, r_resp_flags, w_flags, w_op;
  logic               r_resp_err, w_accept, w_exec_done, w_resp_done;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_op    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
        w_op    = bus.req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) w_owner_oh[i] = (r_owner == IW'(i));
  end

  always_comb begin
    w_flags        = '0;
    w_flags[FLG_Z] = alu_zero;
    w_flags[FLG_C] = alu_carry;
    w_flags[FLG_V] = alu_overflow;
    w_flags[FLG_N] = alu_negative;
  end

  assign w_accept    = (r_state == S_IDLE) && (|w_gnt);
  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == '0);
  assign w_resp_done = (r_state == S_RESP) && (|(bus.resp_ready & w_owner_oh));
  assign w_cnt_load  = is_muldiv(w_op) ? CW'(MULDIV_CYCLES - 1) : '0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_next = S_RESP;
      S_RESP:  if (w_resp_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counter is loaded with cycles-1 so a single-cycle op finishes in its first EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= IW'(NUM_REQ - 1);
      r_owner       <= '0;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctrl    <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_resp_flags  <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a    <= w_sel_a;
        r_alu_b    <= w_sel_b;
        r_alu_ctrl <= w_op;
        r_owner    <= w_gnt_idx;
        r_ptr      <= w_gnt_idx;
        r_cnt      <= w_cnt_load;
      end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_exec_done) begin
        r_resp_result <= is_illegal(r_alu_ctrl) ? '0 : alu_result;
        r_resp_flags  <= w_flags;
        r_resp_err    <= is_illegal(r_alu_ctrl);
        r_resp_valid  <= w_owner_oh;
      end else if (w_resp_done) begin
        r_resp_valid <= '0;
      end
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE) ? w_gnt : '0;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_flags  = r_resp_flags;
  assign bus.resp_err    = r_resp_err;
  assign busy            = (r_state != S_IDLE);
  assign alu_a           = r_alu_a;
  assign alu_b           = r_alu_b;
  assign alu_ctrl        = r_alu_ctrl;

endmodule
